// File: rtl/bot_io_pkg.sv
// Shared definitions for the bot I/O interrupt arbiter: FSM encoding,
// default acknowledge timeout and a small width helper.
package bot_io_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Default acknowledge window in clk50 cycles (20 ms at 50 MHz)
  localparam int TIMEOUT_CYC_DEF = 1000000;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bot_intr_arbiter_rr_pick.sv
// Round-robin picker: returns the first pending source strictly after
// last_grant (wrapping), so the last winner has the lowest priority.
module rr_pick #(
  parameter int NSRC  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NSRC-1:0]  pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int best;
  int d;

  // Rank each pending source by its wrapped distance from last_grant+1
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    best = NSRC;
    d    = 0;
    for (int i = 0; i < NSRC; i++) begin
      d = (i + NSRC - 1 - int'(last_grant)) % NSRC;
      if (pending[i] && d < best) begin
        best = d;
        idx  = IDX_W'(i);
        vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bot_intr_arbiter.sv
// Interrupt arbiter: edge-detects per-source update strobes into pending
// flags, grants one source at a time to the CPU in round-robin order,
// counts overruns and flags acknowledge timeouts.
module bot_intr_arbiter
  import bot_io_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int OVR_W       = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk50,
  input  logic                    resetn,
  input  logic [NSRC-1:0]         upd_req,
  input  logic                    int_ack,
  input  logic                    clr_err,
  output logic                    irq,
  output logic [$clog2(NSRC)-1:0] irq_src,
  output logic [NSRC-1:0]         pending,
  output logic [NSRC*OVR_W-1:0]   ovr_cnt,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(NSRC);
  localparam int TO_W  = cnt_w(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NSRC - 1);

  arb_state_e                 state_q, state_d;
  logic [NSRC-1:0]            upd_q, edge_det, rel_mask, pend_d;
  logic [NSRC-1:0][OVR_W-1:0] ovr_q, ovr_d;
  logic [IDX_W-1:0]           last_grant, pick_idx;
  logic [TO_W-1:0]            tmo_cnt;
  logic                       pick_vld, in_grant, tmo_hit, rel_g;

  assign edge_det = upd_req & ~upd_q;
  assign in_grant = (state_q == ST_GRANT);
  assign tmo_hit  = in_grant && (tmo_cnt == TO_W'(TIMEOUT_CYC - 1));
  // Grant ends on an acknowledge or on the timeout cycle; ack wins the tie
  assign rel_g    = in_grant && (int_ack || tmo_hit);

  // Per-source pending/overrun next state. A fresh edge on the source being
  // released re-arms it rather than counting as an overrun.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic inc;
    assign rel_mask[i] = rel_g && (irq_src == IDX_W'(i));
    assign inc         = edge_det[i] && pending[i] && !rel_mask[i] && (ovr_q[i] != '1);
    assign pend_d[i]   = edge_det[i] | (pending[i] & ~rel_mask[i]);
    assign ovr_d[i]    = clr_err ? '0 : (inc ? ovr_q[i] + OVR_W'(1) : ovr_q[i]);
  end

  rr_pick #(.NSRC(NSRC), .IDX_W(IDX_W)) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .vld        (pick_vld)
  );

  // FSM state register
  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: IDLE grants whenever anything is pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_GRANT;
      ST_GRANT: if (rel_g)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output: irq straight from state so reset drops it immediately
  always_comb irq = in_grant;

  // Input sampling, pending flags and overrun counters
  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      upd_q   <= '0;
      pending <= '0;
      ovr_q   <= '0;
    end else begin
      upd_q   <= upd_req;
      pending <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  // Grant bookkeeping: latched source, round-robin pointer, timeout, error
  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      irq_src     <= '0;
      last_grant  <= LAST_RST;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!in_grant && pick_vld) irq_src <= pick_idx;
      if (rel_g)                 last_grant <= irq_src;
      tmo_cnt <= (in_grant && !rel_g) ? tmo_cnt + TO_W'(1) : '0;
      if (clr_err)                  timeout_err <= 1'b0;
      else if (tmo_hit && !int_ack) timeout_err <= 1'b1;
    end
  end

  assign ovr_cnt = ovr_q;

endmodule

// File: tb/tb_bot_intr_arbiter.sv
// Bench for bot_intr_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a cycle reference model.
module tb_bot_intr_arbiter;

  localparam int NS  = 4;
  localparam int TMO = 16;

  logic          clk50 = 1'b0;
  logic          resetn;
  logic [NS-1:0] upd_req;
  logic          int_ack, clr_err;
  logic          irq;
  logic [1:0]    irq_src;
  logic [NS-1:0] pending;
  logic [NS*8-1:0] ovr_cnt;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  bit mchk  = 0;

  bot_intr_arbiter #(.NSRC(NS), .OVR_W(8), .TIMEOUT_CYC(TMO)) dut (
    .clk50       (clk50),
    .resetn      (resetn),
    .upd_req     (upd_req),
    .int_ack     (int_ack),
    .clr_err     (clr_err),
    .irq         (irq),
    .irq_src     (irq_src),
    .pending     (pending),
    .ovr_cnt     (ovr_cnt),
    .timeout_err (timeout_err)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_grant = granted source or -1 when nobody holds the CPU;
  // m_age = completed GRANT cycles of the current grant.
  bit m_prev [NS];
  bit m_pend [NS];
  int m_ovr  [NS];
  int m_grant, m_src, m_last, m_age;
  bit m_terr;

  task automatic model_step();
    bit ev [NS];
    int rel, newg, c;
    bit tmo;
    rel = -1; newg = -1; tmo = 0;
    for (int i = 0; i < NS; i++) ev[i] = upd_req[i] && !m_prev[i];
    if (m_grant >= 0) begin
      if (int_ack) rel = m_grant;
      else if (m_age == TMO - 1) begin rel = m_grant; tmo = 1; end
    end else begin
      for (int k = 1; k <= NS; k++) begin
        c = (m_last + k) % NS;
        if (newg < 0 && m_pend[c]) newg = c;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (ev[i] && m_pend[i] && i != rel && m_ovr[i] < 255) m_ovr[i]++;
      if (ev[i]) m_pend[i] = 1;
      else if (i == rel) m_pend[i] = 0;
      m_prev[i] = upd_req[i];
    end
    if (clr_err) begin
      for (int i = 0; i < NS; i++) m_ovr[i] = 0;
      m_terr = 0;
    end else if (tmo) m_terr = 1;
    if (rel >= 0) begin m_last = rel; m_grant = -1; end
    else if (newg >= 0) begin m_grant = newg; m_src = newg; m_age = 0; end
    else if (m_grant >= 0) m_age++;
  endtask

  always @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NS; i++) begin m_prev[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; end
      m_grant = -1; m_src = 0; m_last = NS - 1; m_age = 0; m_terr = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk50) begin
    if (mchk) begin
      chk("model_irq", irq, m_grant >= 0);
      chk("model_src", irq_src, m_src);
      chk("model_terr", timeout_err, m_terr);
      for (int i = 0; i < NS; i++) begin
        chk("model_pend", pending[i], m_pend[i]);
        chk("model_ovr", ovr_cnt[i*8 +: 8], m_ovr[i]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk50);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0; upd_req = '0; int_ack = 1'b0; clr_err = 1'b0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic wait_irq(input string nm, output int src);
    int c = 0;
    while (!irq && c < 40) begin step(); c++; end
    chk(nm, irq, 1'b1);
    src = irq_src;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] upd;
    logic       ack;
    logic       e_irq;
    logic [1:0] e_src;
    logic [3:0] e_pend;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int s, n;
    int got [3];

    resetn = 1'b0; upd_req = '0; int_ack = 1'b0; clr_err = 1'b0;
    // single event on 2 with ack, then 0 and 3 together after 2 was served
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[6]  = '{4'b1001, 1'b0, 1'b0, 2'd2, 4'b1001};
    tbl[7]  = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b1001};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

    repeat (3) step();
    chk("rst_irq", irq, 1'b0);
    chk("rst_src", irq_src, 2'd0);
    chk("rst_pend", pending, 4'd0);
    chk("rst_ovr", ovr_cnt, 32'd0);
    chk("rst_terr", timeout_err, 1'b0);
    resetn = 1'b1;
    mchk   = 1'b1;

    for (int k = 0; k < 12; k++) begin
      upd_req = tbl[k].upd;
      int_ack = tbl[k].ack;
      step();
      chk("tbl_irq", irq, tbl[k].e_irq);
      chk("tbl_src", irq_src, tbl[k].e_src);
      chk("tbl_pend", pending, tbl[k].e_pend);
      chk("tbl_ovr", ovr_cnt, 32'd0);
      chk("tbl_terr", timeout_err, 1'b0);
    end
    int_ack = 1'b0;

    // fairness: 0,1,3 together, acked on the third grant cycle each
    do_reset();
    upd_req = 4'b1011; step(); upd_req = '0;
    for (int g = 0; g < 3; g++) begin
      wait_irq("fair_wait", s);
      got[g] = s;
      step(); step();
      pulse_ack();
    end
    chk("fair_g0", got[0], 0);
    chk("fair_g1", got[1], 1);
    chk("fair_g2", got[2], 3);
    upd_req = 4'b0001; step(); upd_req = '0;
    wait_irq("fair_wait", s);
    chk("fair_again", s, 0);
    pulse_ack();

    // overrun saturation on source 1, then clr_err
    do_reset();
    for (int e = 0; e < 300; e++) begin
      upd_req[1] = 1'b1; step();
      upd_req[1] = 1'b0; step();
    end
    chk("ovr_sat", ovr_cnt[15:8], 8'hFF);
    chk("ovr_terr_set", timeout_err, 1'b1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovr_clr", ovr_cnt[15:8], 8'h00);
    chk("ovr_terr_clr", timeout_err, 1'b0);

    // timeout: no ack, grant lasts exactly TMO cycles
    do_reset();
    upd_req = 4'b0100; step(); upd_req = '0;
    wait_irq("tmo_wait", s);
    n = 0;
    while (irq && n < 40) begin n++; step(); end
    chk("tmo_len", n, TMO);
    chk("tmo_err", timeout_err, 1'b1);
    chk("tmo_pend", pending[2], 1'b0);
    chk("tmo_irq", irq, 1'b0);

    // collision: new edge on the granted source with its ack
    do_reset();
    upd_req = 4'b0001; step(); upd_req = '0;
    wait_irq("col_wait", s);
    step();
    upd_req = 4'b0001; int_ack = 1'b1; step();
    upd_req = '0;      int_ack = 1'b0;
    chk("col_irq_gap", irq, 1'b0);
    chk("col_pend", pending[0], 1'b1);
    step();
    chk("col_regrant", irq, 1'b1);
    chk("col_src", irq_src, 2'd0);
    chk("col_ovr", ovr_cnt[7:0], 8'h00);
    pulse_ack();

    // reset mid-grant with 0 and 3 held high through release
    do_reset();
    upd_req = 4'b0100; step(); upd_req = '0;
    wait_irq("mrst_wait", s);
    #2 resetn = 1'b0; upd_req = 4'b1001;
    #1;
    chk("mrst_irq", irq, 1'b0);
    chk("mrst_src", irq_src, 2'd0);
    chk("mrst_pend", pending, 4'd0);
    chk("mrst_terr", timeout_err, 1'b0);
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("mrst_held_edge", pending, 4'b1001);
    wait_irq("mrst_wait2", s);
    chk("mrst_first", s, 0);
    pulse_ack();
    upd_req = '0;

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 3) == 0) upd_req[i] = ~upd_req[i];
      int_ack = ($urandom_range(0, 5) == 0);
      clr_err = ($urandom_range(0, 99) == 0);
      step();
    end
    int_ack = 1'b0; clr_err = 1'b0; upd_req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bot_intr_arbiter.md
BOT_INTR_ARBITER -- requirements
Module: bot_intr_arbiter

Interface
REQ-001 Parameter NSRC, default 4: number of update/interrupt requesters.
REQ-002 Parameter OVR_W, default 8: width of each per-source overrun counter.
REQ-003 Parameter TIMEOUT_CYC, default 1000000: clk50 cycles allowed between irq assertion and int_ack.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; clk50 and resetn are the only clock and reset ports.
REQ-005 clk50  input  1: system clock; all state updates on its rising edge.
REQ-006 resetn  input  1: asynchronous active-low reset.
REQ-007 upd_req  input  NSRC: per-source update strobes, synchronous to clk50; an event is a 0->1 transition.
REQ-008 int_ack  input  1: CPU acknowledge, one-cycle pulse written through the AHB-lite peripheral.
REQ-009 clr_err  input  1: one-cycle pulse; clears timeout_err and all overrun counters.
REQ-010 irq  output  1: interrupt to CPU, level-high while a grant is outstanding.
REQ-011 irq_src  output  $clog2(NSRC): index of the granted source; valid while irq=1.
REQ-012 pending  output  NSRC: per-source pending flags.
REQ-013 ovr_cnt  output  NSRC*OVR_W: packed overrun counters, source i at bits [i*OVR_W +: OVR_W].
REQ-014 timeout_err  output  1: sticky flag, set on an acknowledge timeout.

Function
REQ-015 The block SHALL register upd_req each cycle and detect rising edges against the registered copy.
REQ-016 A rising edge seen in cycle N SHALL set pending[i] at the end of cycle N.
REQ-017 An edge on source i while pending[i]=1 SHALL increment ovr_cnt[i], saturating at all-ones with no wrap.
REQ-018 The FSM SHALL have two states: IDLE (irq=0) and GRANT (irq=1).
REQ-019 In IDLE with any pending bit set, the FSM SHALL select the first pending source at or after (last_grant+1) mod NSRC, latch it into irq_src, and enter GRANT; irq rises one cycle after pending.
REQ-020 From an idle bus, an upd_req edge in cycle N SHALL produce irq=1 in cycle N+2.
REQ-021 In GRANT, int_ack=1 SHALL clear pending[irq_src], set last_grant=irq_src, and return to IDLE; irq is 0 in the next cycle.
REQ-022 int_ack received in IDLE SHALL be ignored.
REQ-023 Minimum spacing between consecutive grants SHALL be one IDLE cycle.
REQ-024 A new edge on irq_src in the same cycle as its int_ack SHALL leave pending set, with no overrun increment; the new event wins.
REQ-025 The timeout counter SHALL reset on entry to GRANT and count while in GRANT.
REQ-026 On reaching TIMEOUT_CYC-1 without int_ack, the block SHALL set timeout_err, clear pending[irq_src], update last_grant, and return to IDLE.
REQ-027 int_ack coincident with the timeout cycle SHALL be treated as a normal acknowledge, with timeout_err unchanged.
REQ-028 clr_err SHALL take priority over a same-cycle overrun increment or timeout set.
REQ-029 irq_src SHALL hold its value while the FSM is in IDLE.

Reset
REQ-030 While resetn=0, the block SHALL force state=IDLE, irq=0, irq_src=0, pending=0, all ovr_cnt=0, timeout_err=0, timeout counter=0, last_grant=NSRC-1 (source 0 wins first), and registered upd_req=0.
REQ-031 Reset asserted mid-GRANT SHALL drop irq asynchronously and discard the outstanding grant.
REQ-032 upd_req held high through reset release SHALL register as one event in the first cycle after release.

Structure
REQ-033 FSM state encoding and the default TIMEOUT_CYC SHALL live in the shared package bot_io_pkg.
REQ-034 Round-robin selection SHALL be one sub-module, rr_pick: combinational, with inputs pending and last_grant and outputs the index and a valid flag.

Verification
REQ-035 Single event: upd_req[2] edge at cycle 10 -> irq=1, irq_src=2 at cycle 12; int_ack at 15 -> irq=0 at 16, pending=0.
REQ-036 Fairness: edges on sources 0, 1 and 3 in one cycle with acks every 3 cycles -> grants in order 0, 1, 3, then source 0 again after its next edge.
REQ-037 Overrun: 300 edges on source 1 with no ack -> ovr_cnt[1]=255 (saturated); clr_err -> 0.
REQ-038 Timeout: TIMEOUT_CYC=16, no ack -> irq drops after 16 GRANT cycles, timeout_err=1, pending[irq_src]=0.
REQ-039 Collision: source 0 edge in the same cycle as its ack -> pending[0] stays 1, re-grant follows one IDLE cycle later, ovr_cnt[0]=0.
REQ-040 Reset mid-grant: resetn low for 3 cycles during GRANT -> all outputs 0 immediately; first grant after release goes to source 0.
